r88_alu_seq: RTL and testbench
==============================

// Module: r88_alu_seq
// PURPOSE
// Initiator side of the r88_alu interface: accepts 8- or 16-bit ALU requests from the decoder and drives r88_alu's operand/control inputs.
// Samples the result from intD and carryOut, chains the carry for the 16-bit high byte, keeps the C/Z/N flag register and returns a result over valid/ready.
// Sits between the instruction decoder and r88_alu; owns the ALU's bus-drive enable.
// PARAMETERS
// SETTLE_CYCLES  1  cycles each byte phase holds ALU controls before sampling intD (>=1)
// PORTS
// sysClock     in   1   system clock, all state on rising edge
// sysResetN    in   1   asynchronous, active-low reset
// reqValid     in   1   request present
// reqReady     out  1   sequencer idle, request accepted when reqValid&reqReady
// reqOp        in   3   ALU operation code, passed to aluOp
// reqWide      in   1   1 = 16-bit operation (low byte then high byte)
// reqUseCarry  in   1   low byte uses flag C as carry-in (ADC/SBC)
// reqInv       in   1   passed to invOut
// reqDec       in   1   passed to decMode
// reqRightSel  in   1   passed to rightSel
// reqLeft      in   16  left operand (high byte ignored when !reqWide)
// reqRight     in   16  right operand (high byte ignored when !reqWide)
// regLeft      out  8   to ALU regLeft
// regRight     out  8   to ALU regRight
// aluOp        out  3   to ALU
// carryIn      out  1   to ALU
// carryInEn    out  1   to ALU
// invOut       out  1   to ALU
// decMode      out  1   to ALU
// rightSel     out  1   to ALU
// aluDrive     out  1   ALU enabled to drive intD
// intD         in   8   ALU result byte, valid while aluDrive=1
// carryOut     in   1   ALU carry out
// respValid    out  1   result/flags valid; held until respReady
// respReady    in   1   consumer accepts response
// respData     out  16  result (high byte 0x00 when !wide)
// flags        out  3   {C,Z,N} flag register
// flagLoad     in   1   direct flag write (POP F etc.)
// flagIn       in   3   {C,Z,N} value for flagLoad
// BEHAVIOUR
// - Reset: state IDLE; reqReady=1; respValid=0, aluDrive=0, respData=0, flags=0; all ALU control outputs and regLeft/regRight=0.
// - States IDLE -> LO -> (HI if wide) -> RESP -> IDLE. Request latched on accept; reqReady=1 only in IDLE.
// - LO: drive low bytes and latched controls, aluDrive=1, carryInEn=reqUseCarry, carryIn=flag C at accept. Hold SETTLE_CYCLES cycles, sample intD/carryOut on the last one.
// - HI: drive high bytes, carryInEn=isArith(op), carryIn=sampled LO carryOut, same settle/sample rule.
// - aluDrive=0 and controls return to 0 in IDLE and RESP.
// - Enter RESP: respData, C=final carryOut, Z=(all result bits of the active width ==0), N=MSB of the active width. Flags update once, on entry to RESP.
// - Latency at SETTLE_CYCLES=1: accept at T, respValid from T+2 (byte) or T+3 (wide).
// - RESP -> IDLE on respReady. No overlap: next request accepted the cycle after the handshake.
// - respData/flags stable while respValid=1 and respReady=0.
// - flagLoad: writes flags in any state. Same cycle as RESP-entry flag update: sequencer update wins and flagLoad is dropped.
// - reqValid while busy is ignored (reqReady=0); request inputs are don't-care outside accept.
// - Reset asserted mid-operation: immediate return to reset values, no partial response.
// STRUCTURE
// - r88_pkg: state encoding, flag bit indices, ALU op codes, isArith() function (ADD/SUB class ops).
// - Settle counter is internal, no sub-module. Single module r88_alu_seq. Bench pairs it with r88_alu via intD.
// TESTING
// - Byte ADD 0x3C+0x05, reqUseCarry=0 -> respValid at T+2, respData=0x0041, flags C=0,Z=0,N=0.
// - Wide ADD 0x00FF+0x0001 -> HI carryInEn=1, carryIn=1, respData=0x0100, C=0,Z=0,N=0 at T+3.
// - Byte SUB 0x12-0x12 -> respData=0x0000, Z=1. Next byte op 0x80 result -> N=1, Z=0.
// - respReady low 5 cycles -> respData/flags held, reqReady=0, new reqValid ignored; accepted the cycle after the handshake.
// - sysResetN low during HI of a wide op -> outputs at reset values, aluDrive=0, no respValid afterwards.
// - flagLoad={1,0,0} in IDLE -> flags=3'b100. Same cycle as RESP entry of a 0x00 result -> flags=3'b010.

Source files
------------

// File: rtl/r88_pkg.sv
// Shared definitions for the r88 ALU sequencer: state encoding, flag layout,
// ALU operation codes and the arithmetic-class test used for carry chaining.
package r88_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_RESP = 2'd3
  } seqState_t;

  localparam int FLAG_C = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;

  // Only ADD/SUB class ops propagate a carry/borrow into the high byte.
  function automatic logic isArith(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

  function automatic logic [2:0] packFlags(input logic c, input logic z, input logic n);
    logic [2:0] f;
    f         = '0;
    f[FLAG_C] = c;
    f[FLAG_Z] = z;
    f[FLAG_N] = n;
    return f;
  endfunction

endpackage

// File: rtl/r88_alu_seq.sv
// Initiator side of the r88_alu interface: sequences 8/16-bit ALU requests
// byte by byte over the shared result bus and owns the C/Z/N flag register.
module r88_alu_seq
  import r88_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic        sysClock,
  input  logic        sysResetN,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic [2:0]  reqOp,
  input  logic        reqWide,
  input  logic        reqUseCarry,
  input  logic        reqInv,
  input  logic        reqDec,
  input  logic        reqRightSel,
  input  logic [15:0] reqLeft,
  input  logic [15:0] reqRight,
  output logic [7:0]  regLeft,
  output logic [7:0]  regRight,
  output logic [2:0]  aluOp,
  output logic        carryIn,
  output logic        carryInEn,
  output logic        invOut,
  output logic        decMode,
  output logic        rightSel,
  output logic        aluDrive,
  input  logic [7:0]  intD,
  input  logic        carryOut,
  output logic        respValid,
  input  logic        respReady,
  output logic [15:0] respData,
  output logic [2:0]  flags,
  input  logic        flagLoad,
  input  logic [2:0]  flagIn
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  seqState_t        state, nextState;
  logic [CNT_W-1:0] settleCnt;
  logic             lastSettle;

  logic [2:0]  opReg;
  logic        wideReg, useCarryReg, invReg, decReg, rightSelReg;
  logic [15:0] leftReg, rightReg;
  logic        carrySnap;
  logic [7:0]  loResult;
  logic        loCarry;
  logic [15:0] respReg;
  logic [2:0]  flagReg;

  assign lastSettle = (settleCnt == CNT_LAST);
  assign respData   = respReg;
  assign flags      = flagReg;

  always_ff @(posedge sysClock or negedge sysResetN) begin
    if (!sysResetN) begin
      state       <= ST_IDLE;
      settleCnt   <= '0;
      opReg       <= '0;
      wideReg     <= 1'b0;
      useCarryReg <= 1'b0;
      invReg      <= 1'b0;
      decReg      <= 1'b0;
      rightSelReg <= 1'b0;
      leftReg     <= '0;
      rightReg    <= '0;
      carrySnap   <= 1'b0;
      loResult    <= '0;
      loCarry     <= 1'b0;
      respReg     <= '0;
      flagReg     <= '0;
    end else begin
      state <= nextState;

      if ((state == ST_LO) || (state == ST_HI))
        settleCnt <= lastSettle ? '0 : settleCnt + 1'b1;
      else
        settleCnt <= '0;

      if ((state == ST_IDLE) && reqValid) begin
        opReg       <= reqOp;
        wideReg     <= reqWide;
        useCarryReg <= reqUseCarry;
        invReg      <= reqInv;
        decReg      <= reqDec;
        rightSelReg <= reqRightSel;
        leftReg     <= reqLeft;
        rightReg    <= reqRight;
        carrySnap   <= flagReg[FLAG_C];
      end

      if ((state == ST_LO) && lastSettle) begin
        loResult <= intD;
        loCarry  <= carryOut;
      end

      // The sequencer's own flag update on RESP entry takes priority over flagLoad.
      if ((state == ST_LO) && lastSettle && !wideReg) begin
        respReg <= {8'h00, intD};
        flagReg <= packFlags(carryOut, intD == 8'h00, intD[7]);
      end else if ((state == ST_HI) && lastSettle) begin
        respReg <= {intD, loResult};
        flagReg <= packFlags(carryOut, {intD, loResult} == 16'h0000, intD[7]);
      end else if (flagLoad) begin
        flagReg <= flagIn;
      end
    end
  end

  always_comb begin
    nextState = state;
    reqReady  = 1'b0;
    respValid = 1'b0;
    regLeft   = '0;
    regRight  = '0;
    aluOp     = '0;
    carryIn   = 1'b0;
    carryInEn = 1'b0;
    invOut    = 1'b0;
    decMode   = 1'b0;
    rightSel  = 1'b0;
    aluDrive  = 1'b0;

    case (state)
      ST_IDLE: begin
        reqReady = 1'b1;
        if (reqValid) nextState = ST_LO;
      end
      ST_LO: begin
        regLeft   = leftReg[7:0];
        regRight  = rightReg[7:0];
        aluOp     = opReg;
        invOut    = invReg;
        decMode   = decReg;
        rightSel  = rightSelReg;
        aluDrive  = 1'b1;
        carryInEn = useCarryReg;
        carryIn   = carrySnap;
        if (lastSettle) nextState = wideReg ? ST_HI : ST_RESP;
      end
      ST_HI: begin
        regLeft   = leftReg[15:8];
        regRight  = rightReg[15:8];
        aluOp     = opReg;
        invOut    = invReg;
        decMode   = decReg;
        rightSel  = rightSelReg;
        aluDrive  = 1'b1;
        carryInEn = isArith(opReg);
        carryIn   = loCarry;
        if (lastSettle) nextState = ST_RESP;
      end
      ST_RESP: begin
        respValid = 1'b1;
        if (respReady) nextState = ST_IDLE;
      end
      default: nextState = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_r88_alu_seq.sv
// Randomized bench for r88_alu_seq with a simple byte ALU stand-in on intD and
// a whole-word arithmetic reference model for results and flags.
module tb_r88_alu_seq;
  import r88_pkg::*;

  logic        sysClock = 1'b0;
  logic        sysResetN;
  logic        reqValid, reqReady;
  logic [2:0]  reqOp;
  logic        reqWide, reqUseCarry, reqInv, reqDec, reqRightSel;
  logic [15:0] reqLeft, reqRight;
  logic [7:0]  regLeft, regRight;
  logic [2:0]  aluOp;
  logic        carryIn, carryInEn, invOut, decMode, rightSel, aluDrive;
  logic [7:0]  intD;
  logic        carryOut;
  logic        respValid, respReady;
  logic [15:0] respData;
  logic [2:0]  flags;
  logic        flagLoad;
  logic [2:0]  flagIn;

  int          checks = 0;
  int          failures = 0;
  logic [2:0]  refFlags;

  always #5 sysClock = ~sysClock;

  r88_alu_seq #(.SETTLE_CYCLES(1)) dut (
    .sysClock(sysClock), .sysResetN(sysResetN),
    .reqValid(reqValid), .reqReady(reqReady), .reqOp(reqOp), .reqWide(reqWide),
    .reqUseCarry(reqUseCarry), .reqInv(reqInv), .reqDec(reqDec), .reqRightSel(reqRightSel),
    .reqLeft(reqLeft), .reqRight(reqRight),
    .regLeft(regLeft), .regRight(regRight), .aluOp(aluOp), .carryIn(carryIn),
    .carryInEn(carryInEn), .invOut(invOut), .decMode(decMode), .rightSel(rightSel),
    .aluDrive(aluDrive), .intD(intD), .carryOut(carryOut),
    .respValid(respValid), .respReady(respReady), .respData(respData), .flags(flags),
    .flagLoad(flagLoad), .flagIn(flagIn)
  );

  // Byte-wide ALU stand-in; SUB reports a borrow as carry, bus floats to junk when not driven.
  logic [8:0] aluSum;
  logic       aluCin;
  always_comb begin
    aluCin = carryInEn & carryIn;
    case (aluOp)
      OP_ADD:  aluSum = {1'b0, regLeft} + {1'b0, regRight} + {8'h00, aluCin};
      OP_SUB:  aluSum = {1'b0, regLeft} - {1'b0, regRight} - {8'h00, aluCin};
      OP_AND:  aluSum = {1'b0, regLeft & regRight};
      OP_OR:   aluSum = {1'b0, regLeft | regRight};
      OP_XOR:  aluSum = {1'b0, regLeft ^ regRight};
      default: aluSum = {1'b0, regLeft};
    endcase
    intD     = aluDrive ? aluSum[7:0] : 8'h5A;
    carryOut = aluDrive & aluSum[8];
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
    end
  endtask

  // Whole-operand reference: the 16-bit result is one arithmetic operation, not a byte chain.
  task automatic refCompute(input logic [2:0] op, input logic wide, input logic cin,
                            input logic [15:0] l, input logic [15:0] r,
                            output logic [15:0] res, output logic c, output logic loC);
    int a, b, s, mask, la, lb;
    mask = wide ? 65535 : 255;
    a    = wide ? int'(l) : int'(l[7:0]);
    b    = wide ? int'(r) : int'(r[7:0]);
    la   = int'(l[7:0]);
    lb   = int'(r[7:0]);
    c    = 1'b0;
    loC  = 1'b0;
    case (op)
      OP_ADD: begin s = a + b + int'(cin); c = (s > mask); loC = (la + lb + int'(cin)) > 255; end
      OP_SUB: begin s = a - b - int'(cin); c = (s < 0);    loC = (la - lb - int'(cin)) < 0;   end
      OP_AND: s = a & b;
      OP_OR:  s = a | b;
      OP_XOR: s = a ^ b;
      default: s = a;
    endcase
    res = 16'(s & mask);
  endtask

  task automatic pokeFlags(input logic [2:0] v);
    flagLoad = 1'b1;
    flagIn   = v;
    @(negedge sysClock);
    flagLoad = 1'b0;
    refFlags = v;
    checkOutput("flag_load", 32'(flags), 32'(v));
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic wide, input logic useCarry,
                               input logic inv, input logic dec, input logic rsel,
                               input logic [15:0] l, input logic [15:0] r,
                               input int holdCycles, input logic busyPoke, input logic flagPoke);
    logic [15:0] expRes;
    logic        expC, expLoC, cin;
    logic [2:0]  expFlags;
    int          lat;
    cin = useCarry & refFlags[FLAG_C];
    refCompute(op, wide, cin, l, r, expRes, expC, expLoC);
    expFlags = {expC, expRes == 16'h0000, wide ? expRes[15] : expRes[7]};

    reqOp = op; reqWide = wide; reqUseCarry = useCarry;
    reqInv = inv; reqDec = dec; reqRightSel = rsel;
    reqLeft = l; reqRight = r; reqValid = 1'b1;
    checkOutput("req_ready_idle", 32'(reqReady), 32'd1);

    lat = 0;
    do begin
      @(negedge sysClock);
      lat++;
      if (lat == 1) begin
        reqValid = 1'b0;
        reqOp = 3'($urandom); reqWide = 1'($urandom); reqUseCarry = 1'($urandom);
        reqLeft = 16'($urandom); reqRight = 16'($urandom);
        checkOutput("lo_drive", 32'({aluDrive, reqReady}), 32'b10);
        checkOutput("lo_operands", 32'({regLeft, regRight}), 32'({l[7:0], r[7:0]}));
        checkOutput("lo_ctrl", 32'({aluOp, invOut, decMode, rightSel, carryInEn, carryIn}),
                    32'({op, inv, dec, rsel, useCarry, refFlags[FLAG_C]}));
        if (flagPoke) begin
          flagLoad = 1'b1;
          flagIn   = 3'b101;
        end
      end else if (lat == 2) begin
        flagLoad = 1'b0;
        if (wide) begin
          checkOutput("hi_drive", 32'(aluDrive), 32'd1);
          checkOutput("hi_operands", 32'({regLeft, regRight}), 32'({l[15:8], r[15:8]}));
          checkOutput("hi_carry", 32'({carryInEn, carryIn}),
                      32'({(op == OP_ADD) || (op == OP_SUB), expLoC}));
        end
      end
    end while (!respValid && lat < 20);
    flagLoad = 1'b0;

    checkOutput("latency", 32'(lat), wide ? 32'd3 : 32'd2);
    checkOutput("resp_data", 32'(respData), 32'(expRes));
    checkOutput("resp_flags", 32'(flags), 32'(expFlags));
    checkOutput("resp_state", 32'({respValid, reqReady, aluDrive}), 32'b100);
    refFlags = expFlags;

    for (int i = 0; i < holdCycles; i++) begin
      if (busyPoke) begin
        reqValid = 1'b1; reqOp = OP_ADD; reqWide = 1'b0; reqUseCarry = 1'b0;
        reqInv = 1'b0; reqDec = 1'b0; reqRightSel = 1'b0;
        reqLeft = 16'h0011; reqRight = 16'h0022;
      end
      @(negedge sysClock);
      checkOutput("hold_data", 32'(respData), 32'(expRes));
      checkOutput("hold_flags", 32'(flags), 32'(expFlags));
      checkOutput("hold_state", 32'({respValid, reqReady}), 32'b10);
    end

    respReady = 1'b1;
    @(negedge sysClock);
    respReady = 1'b0;
    if (!busyPoke) reqValid = 1'b0;
    checkOutput("post_handshake", 32'({respValid, reqReady, aluDrive}), 32'b010);
  endtask

  initial begin
    logic [2:0] rop;
    sysResetN = 1'b0; reqValid = 1'b0; respReady = 1'b0; flagLoad = 1'b0; flagIn = '0;
    reqOp = '0; reqWide = 1'b0; reqUseCarry = 1'b0; reqInv = 1'b0; reqDec = 1'b0;
    reqRightSel = 1'b0; reqLeft = '0; reqRight = '0;
    refFlags = '0;

    repeat (2) @(negedge sysClock);
    checkOutput("reset_hs", 32'({reqReady, respValid, aluDrive}), 32'b100);
    checkOutput("reset_data", 32'(respData), 32'd0);
    checkOutput("reset_flags", 32'(flags), 32'd0);
    checkOutput("reset_alu", 32'({regLeft, regRight, aluOp, carryIn, carryInEn, invOut, decMode, rightSel}), 32'd0);
    sysResetN = 1'b1;
    @(negedge sysClock);

    applyStimulus(OP_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h003C, 16'h0005, 0, 1'b0, 1'b0);
    applyStimulus(OP_ADD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h00FF, 16'h0001, 0, 1'b0, 1'b0);
    applyStimulus(OP_SUB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0012, 16'h0012, 0, 1'b0, 1'b1);
    applyStimulus(OP_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0070, 16'h0010, 0, 1'b0, 1'b0);
    pokeFlags(3'b100);
    applyStimulus(OP_ADD, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h003C, 16'h0005, 0, 1'b0, 1'b0);
    applyStimulus(OP_XOR, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'hA5A5, 16'h0FF0, 5, 1'b1, 1'b0);
    applyStimulus(OP_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0011, 16'h0022, 0, 1'b0, 1'b0);

    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 3) == 0) pokeFlags(3'($urandom_range(0, 7)));
      rop = 3'($urandom_range(0, 4));
      applyStimulus(rop, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                    16'($urandom), 16'($urandom), $urandom_range(0, 2), 1'b0, 1'b0);
    end

    // Reset in the middle of the high-byte phase must abort without a response.
    reqOp = OP_ADD; reqWide = 1'b1; reqUseCarry = 1'b0;
    reqLeft = 16'h1234; reqRight = 16'h1111; reqValid = 1'b1;
    @(negedge sysClock);
    reqValid = 1'b0;
    @(negedge sysClock);
    checkOutput("rst_pre_hi", 32'({aluDrive, regLeft}), 32'({1'b1, 8'h12}));
    #2 sysResetN = 1'b0;
    #1;
    checkOutput("rst_mid_hs", 32'({reqReady, respValid, aluDrive}), 32'b100);
    checkOutput("rst_mid_data", 32'({respData, flags}), 32'd0);
    checkOutput("rst_mid_alu", 32'({regLeft, regRight, aluOp, carryIn, carryInEn}), 32'd0);
    refFlags = '0;
    @(negedge sysClock);
    sysResetN = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge sysClock);
      checkOutput("rst_after", 32'({respValid, reqReady, aluDrive}), 32'b010);
    end
    checkOutput("rst_after_flags", 32'(flags), 32'(refFlags));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
